// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data memory (single write port, single read
// port) between the core datapath and a host/debug loader. The core has
// priority, and a saturating wait counter guarantees that the host wins after
// MAX_WAIT consecutive lost cycles. The winning command is registered toward
// the memory, and read data returns to the winner two cycles after its grant.
module mem_port_arbiter #(
   parameter int AW       = 10,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 3
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_stall,
   output logic          core_rvalid,

   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,

   output logic [DW-1:0] rdata,

   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [AW-1:0] mem_raddr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
   localparam logic             OWNER_CORE = 1'b0;
   localparam logic             OWNER_HOST = 1'b1;

   // Host starvation counter.
   logic [CNT_W-1:0] host_wait;
   logic             host_urgent;

   // Winning request, selected combinationally.
   logic             any_gnt;
   logic             sel_we;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_wdata;
   logic             sel_owner;

   // Command stage: registered command on the memory pins.
   logic [AW-1:0]    cmd_addr;
   logic             cmd_rd;
   logic             cmd_owner;

   // Response stage: read data on mem_rdata belongs to this owner.
   logic             rsp_valid;
   logic             rsp_owner;

   // Arbitration: a starved host overrides the core, otherwise the core wins.
   always_comb begin
      host_urgent = host_req && (host_wait == WAIT_LIMIT);
      core_gnt    = core_req && !host_urgent;
      host_gnt    = host_req && (host_urgent || !core_req);
      core_stall  = core_req && !core_gnt;
   end

   assign any_gnt = core_gnt || host_gnt;

   // Select the granted requester's command fields.
   // NOTE: every signal gets a default before the if, so no latch can be inferred.
   always_comb begin
      sel_we    = core_we;
      sel_addr  = core_addr;
      sel_wdata = core_wdata;
      sel_owner = OWNER_CORE;
      if (host_gnt) begin
         sel_we    = host_we;
         sel_addr  = host_addr;
         sel_wdata = host_wdata;
         sel_owner = OWNER_HOST;
      end
   end

   // Count consecutive cycles the host has waited; saturate at the limit.
   // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         host_wait <= '0;
      end else if (!host_req || host_gnt) begin
         host_wait <= '0;
      end else if (host_wait != WAIT_LIMIT) begin
         host_wait <= host_wait + 1'b1;
      end
   end

   // Capture the granted command. Address and data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we    <= 1'b0;
         cmd_addr  <= '0;
         mem_wdata <= '0;
         cmd_rd    <= 1'b0;
         cmd_owner <= OWNER_CORE;
      end else begin
         mem_we <= any_gnt && sel_we;
         cmd_rd <= any_gnt && !sel_we;
         if (any_gnt) begin
            cmd_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cmd_owner <= sel_owner;
         end
      end
   end

   assign mem_waddr = cmd_addr;
   assign mem_raddr = cmd_addr;

   // Track which owner gets mem_rdata in the cycle after a read command.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_owner <= OWNER_CORE;
      end else begin
         rsp_valid <= cmd_rd;
         rsp_owner <= cmd_owner;
      end
   end

   assign core_rvalid = rsp_valid && (rsp_owner == OWNER_CORE);
   assign host_rvalid = rsp_valid && (rsp_owner == OWNER_HOST);
   assign rdata       = rsp_valid ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single data memory (one write port, one read port, 10-bit address, 16-bit data) between the core datapath and a host/debug loader. It sits between the instruction decoder/write-back path and the memory instance in the top level, registers the winning command toward the memory, and returns read data to the winner. Core has priority; a wait counter bounds host starvation. A stall output freezes the core's program counter and decoder while the core loses arbitration.

## Interface
- AW, 10, memory address width
- DW, 16, data width
- MAX_WAIT, 4, consecutive host-waiting cycles after which the host wins over the core (1..7)
- CNT_W, 3, width of the host wait counter; must hold MAX_WAIT
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- core_req  input  1  core requests a memory access this cycle
- core_we  input  1  1 = write, 0 = read
- core_addr  input  AW  core address
- core_wdata  input  DW  core write data
- core_gnt  output  1  core request accepted this cycle (combinational)
- core_stall  output  1  core_req & !core_gnt
- core_rvalid  output  1  core read data valid on rdata
- host_req, host_we, host_addr, host_wdata  input  1/1/AW/DW  host equivalents
- host_gnt  output  1  host request accepted this cycle (combinational)
- host_rvalid  output  1  host read data valid on rdata
- rdata  output  DW  read data returned to the owner flagged by *_rvalid
- mem_we  output  1  registered memory write enable
- mem_waddr, mem_raddr  output  AW  registered memory write/read address
- mem_wdata  output  DW  registered memory write data
- mem_rdata  input  DW  memory read data, valid one cycle after mem_raddr is driven

## Operation
- One transaction accepted per cycle at most; exactly one of core_gnt/host_gnt high when any req is high.
- Arbitration: if host_wait == MAX_WAIT and host_req → host wins; else core_req → core wins; else host_req → host wins.
- host_wait: cleared on rst, on host_gnt, or when host_req is low; else increments by 1 each cycle host_req & !host_gnt; saturates at MAX_WAIT.
- Command stage (registered): on grant, capture we, addr, wdata, owner. mem_we = captured we of a valid command, else 0. mem_waddr and mem_raddr both driven from captured addr; mem_wdata from captured wdata. With no grant, mem_we = 0 and addresses hold last value.
- Response stage: a read command issued in the command stage produces *_rvalid for its owner one cycle later with rdata = mem_rdata. Writes produce no response.
- No forwarding; memory observes commands in grant order, so a read after a write to the same address returns the memory's own read-after-write result.
- Requester must hold req/we/addr/wdata stable until it sees its gnt; dropping req before gnt is allowed and abandons the request.

## Timing
- Reset values: mem_we 0, mem_waddr/mem_raddr 0, mem_wdata 0, rdata 0, core_rvalid 0, host_rvalid 0, host_wait 0, command/response valid 0. gnt/stall are combinational from req and host_wait only.
- Cycle N: req and gnt. N+1: command on mem_* pins. N+2: *_rvalid and rdata for reads. Read latency req→rvalid = 2 cycles; back-to-back grants give one rvalid per cycle.
- Simultaneous core_req and host_req with host_wait < MAX_WAIT: core granted, host_wait increments.
- host_wait reaching MAX_WAIT: the host is granted on the cycle host_wait == MAX_WAIT; core_stall high that cycle.
- rst asserted mid-operation: in-flight command and response discarded; no rvalid after the reset cycle; mem_we low in the cycle after rst is sampled.

## Test plan
- Reset: hold rst 2 cycles with both reqs high → all mem_* and rvalid 0, host_wait 0; gnt follows req combinationally.
- Core read alone: core_req, we=0, addr=0x05 at N → core_gnt at N, mem_raddr=0x05 at N+1, core_rvalid=1 with rdata=mem_rdata at N+2, host_rvalid=0.
- Host write then read: host writes 0xBEEF to 0x3FF, then reads 0x3FF → mem_we=1 with mem_waddr=0x3FF, mem_wdata=0xBEEF one cycle after first gnt; host_rvalid with rdata=0xBEEF two cycles after second gnt.
- Starvation: core_req and host_req held continuously, MAX_WAIT=4 → core granted 4 cycles, host granted 5th cycle, pattern repeats (host every 5th cycle); core_stall high exactly on host cycles.
- Back-to-back mixed reads: alternating core/host reads each cycle with core idle on odd cycles → one rvalid per cycle, owner matches granting order, no dropped or duplicated responses.
- Reset mid-read: rst asserted in cycle N+1 of a core read → no core_rvalid at N+2, mem_we 0, host_wait 0.
